// File: rtl/accum_sequencer_16bit_if.sv
// Bus bundle for accum_sequencer_16bit.
// Carries the sample input handshake, the adder operand/result path and the
// result output handshake. clk/rst are not part of the bundle.
//   slave  : the sequencer side (drives in_ready, adder_a/b/cin, out_*, busy)
//   master : the environment side (drives samples, adder results, out_ready, clear)
interface accum_sequencer_16bit_if #(
  parameter int unsigned WIDTH = 16
);
  logic             clear;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [WIDTH-1:0] adder_a;
  logic [WIDTH-1:0] adder_b;
  logic             adder_cin;
  logic [WIDTH-1:0] adder_sum;
  logic             adder_overflow;
  logic             out_valid;
  logic [WIDTH-1:0] out_sum;
  logic             out_overflow;
  logic             out_ready;
  logic             busy;

  modport slave (
    input  clear, in_valid, in_data, adder_sum, adder_overflow, out_ready,
    output in_ready, adder_a, adder_b, adder_cin, out_valid, out_sum, out_overflow, busy
  );

  modport master (
    output clear, in_valid, in_data, adder_sum, adder_overflow, out_ready,
    input  in_ready, adder_a, adder_b, adder_cin, out_valid, out_sum, out_overflow, busy
  );
endinterface

// File: rtl/accum_sequencer_16bit.sv
// Operand sequencer and result capture for an external combinational 16-bit adder.
// Accumulates NUM_SAMPLES accepted samples (a = acc, b = sample, cin = 0) and
// presents the total plus a sticky overflow flag on a valid/ready output.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (priority over clear)
//   bus  : accum_sequencer_16bit_if.slave
//          clear, in_valid/in_data/in_ready, adder_a/b/cin, adder_sum/overflow,
//          out_valid/out_sum/out_overflow/out_ready, busy
//
// Configuration:
//   ACCUM_SATURATE_EN : when defined, an overflowing beat pins acc to all-ones
//                       until the result is taken; otherwise acc wraps.
module accum_sequencer_16bit #(
  parameter int unsigned NUM_SAMPLES = 4,
  parameter int unsigned WIDTH       = 16
) (
  input logic                   clk,
  input logic                   rst,
  accum_sequencer_16bit_if.slave bus
);

  localparam int unsigned CntW = $clog2(NUM_SAMPLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(NUM_SAMPLES);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [CntW-1:0]  cnt_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic             accept;
  logic [CntW-1:0]  cnt_inc;
  logic [WIDTH-1:0] acc_next;

  assign accept  = bus.in_valid & in_ready_q;
  assign cnt_inc = cnt_q + 1'b1;

`ifdef ACCUM_SATURATE_EN
  // ovf_q can only be set by an overflow, so it doubles as the "saturated" flag.
  assign acc_next = (ovf_q | bus.adder_overflow) ? {WIDTH{1'b1}} : bus.adder_sum;
`else
  assign acc_next = bus.adder_sum;
`endif

  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StAccum: begin
          if (accept) begin
            acc_q  <= acc_next;
            ovf_q  <= ovf_q | bus.adder_overflow;
            cnt_q  <= cnt_inc;
            busy_q <= 1'b1;
            if (cnt_inc == CntLast) begin
              state_q     <= StDone;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= StAccum;
            end
          end
        end
        StDone: begin
          // acc/ovf are untouched here, so out_sum/out_overflow hold while stalled.
          if (bus.out_ready) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          acc_q       <= '0;
          cnt_q       <= '0;
          ovf_q       <= 1'b0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.adder_a      = acc_q;
  assign bus.adder_b      = bus.in_data;
  assign bus.adder_cin    = 1'b0;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_sum      = acc_q;
  assign bus.out_overflow = ovf_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_accum_sequencer_16bit.sv
// Directed bench for accum_sequencer_16bit: one instance with NUM_SAMPLES=4 and
// one with NUM_SAMPLES=1, each fed by a behavioural 16-bit adder.
module tb_accum_sequencer_16bit;

  logic clk;
  logic rst;

  int unsigned n_vec;
  int unsigned n_err;

  accum_sequencer_16bit_if #(.WIDTH(16)) bus4 ();
  accum_sequencer_16bit_if #(.WIDTH(16)) bus1 ();

  accum_sequencer_16bit #(.NUM_SAMPLES(4), .WIDTH(16)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  accum_sequencer_16bit #(.NUM_SAMPLES(1), .WIDTH(16)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // External ripple adder behaviour: {carry_out, sum} = a + b + cin.
  assign {bus4.adder_overflow, bus4.adder_sum} =
    {1'b0, bus4.adder_a} + {1'b0, bus4.adder_b} + {16'h0, bus4.adder_cin};
  assign {bus1.adder_overflow, bus1.adder_sum} =
    {1'b0, bus1.adder_a} + {1'b0, bus1.adder_b} + {16'h0, bus1.adder_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Four back-to-back beats into the NUM_SAMPLES=4 instance.
  task automatic feed(input logic [15:0] v0, input logic [15:0] v1,
                      input logic [15:0] v2, input logic [15:0] v3);
    logic [15:0] v [4];
    v = '{v0, v1, v2, v3};
    for (int i = 0; i < 4; i++) begin
      bus4.in_valid = 1'b1;
      bus4.in_data  = v[i];
      tick();
    end
    bus4.in_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_t2;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus4.clear = 1'b0; bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b0;
    bus1.clear = 1'b0; bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst_out_valid", bus4.out_valid, 0);
    check_eq("rst_out_sum", bus4.out_sum, 0);
    check_eq("rst_out_ovf", bus4.out_overflow, 0);
    check_eq("rst_busy", bus4.busy, 0);
    check_eq("rst_in_ready", bus4.in_ready, 1);
    check_eq("adder_cin", bus4.adder_cin, 0);
    bus4.in_data = 16'h5A5A;
    #1;
    check_eq("adder_b_mirror", bus4.adder_b, 16'h5A5A);

    // 1: 1+2+3+4 = 0x000A
    bus4.out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus4.in_valid = 1'b1;
      bus4.in_data  = 16'(i);
      tick();
    end
    check_eq("t1_pre_valid", bus4.out_valid, 0);
    check_eq("t1_busy", bus4.busy, 1);
    check_eq("t1_adder_a", bus4.adder_a, 16'h0006);
    bus4.in_data = 16'h0004;
    tick();
    bus4.in_valid = 1'b0;
    check_eq("t1_out_valid", bus4.out_valid, 1);
    check_eq("t1_out_sum", bus4.out_sum, 16'h000A);
    check_eq("t1_out_ovf", bus4.out_overflow, 0);
    check_eq("t1_in_ready", bus4.in_ready, 0);
    tick();
    check_eq("t1_taken_valid", bus4.out_valid, 0);
    check_eq("t1_taken_busy", bus4.busy, 0);

    // 2: overflow, then 3: stall for 5 cycles with new input offered
`ifdef ACCUM_SATURATE_EN
    exp_t2 = 16'hFFFF;
`else
    exp_t2 = 16'h0001;
`endif
    bus4.out_ready = 1'b0;
    feed(16'hFFFF, 16'h0002, 16'h0000, 16'h0000);
    check_eq("t2_out_valid", bus4.out_valid, 1);
    check_eq("t2_out_sum", bus4.out_sum, exp_t2);
    check_eq("t2_out_ovf", bus4.out_overflow, 1);
    for (int i = 0; i < 5; i++) begin
      bus4.in_valid = 1'b1;
      bus4.in_data  = 16'h7777;
      tick();
      check_eq("t3_hold_valid", bus4.out_valid, 1);
      check_eq("t3_hold_sum", bus4.out_sum, exp_t2);
      check_eq("t3_hold_ovf", bus4.out_overflow, 1);
      check_eq("t3_in_ready", bus4.in_ready, 0);
    end
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    tick();
    check_eq("t3_idle_valid", bus4.out_valid, 0);
    check_eq("t3_idle_ready", bus4.in_ready, 1);
    check_eq("t3_idle_ovf", bus4.out_overflow, 0);
    check_eq("t3_idle_busy", bus4.busy, 0);

    // 4: clear with a sample present after two beats
    bus4.in_valid = 1'b1;
    bus4.in_data  = 16'h0010;
    tick();
    bus4.in_data  = 16'h0020;
    tick();
    check_eq("t4_acc", bus4.adder_a, 16'h0030);
    bus4.clear   = 1'b1;
    bus4.in_data = 16'h0100;
    tick();
    bus4.clear    = 1'b0;
    bus4.in_valid = 1'b0;
    check_eq("t4_clr_acc", bus4.adder_a, 0);
    check_eq("t4_clr_busy", bus4.busy, 0);
    check_eq("t4_clr_ready", bus4.in_ready, 1);
    feed(16'h0001, 16'h0001, 16'h0001, 16'h0001);
    check_eq("t4_valid", bus4.out_valid, 1);
    check_eq("t4_sum", bus4.out_sum, 16'h0004);
    tick();

    // clear beats out_ready in DONE
    bus4.out_ready = 1'b0;
    feed(16'h0003, 16'h0003, 16'h0003, 16'h0003);
    check_eq("clr_done_valid_pre", bus4.out_valid, 1);
    bus4.clear     = 1'b1;
    bus4.out_ready = 1'b1;
    tick();
    bus4.clear = 1'b0;
    check_eq("clr_done_valid", bus4.out_valid, 0);
    check_eq("clr_done_sum", bus4.out_sum, 0);

    // 5: reset in ACCUM and in DONE
    bus4.in_valid = 1'b1;
    bus4.in_data  = 16'h0005;
    tick();
    bus4.in_data  = 16'h0006;
    tick();
    bus4.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t5a_valid", bus4.out_valid, 0);
    check_eq("t5a_busy", bus4.busy, 0);
    check_eq("t5a_ready", bus4.in_ready, 1);
    check_eq("t5a_acc", bus4.adder_a, 0);
    bus4.out_ready = 1'b0;
    feed(16'h0001, 16'h0001, 16'h0001, 16'h0001);
    check_eq("t5b_sum_fresh", bus4.out_sum, 16'h0004);
    check_eq("t5b_valid_pre", bus4.out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t5b_valid", bus4.out_valid, 0);
    check_eq("t5b_busy", bus4.busy, 0);
    check_eq("t5b_ready", bus4.in_ready, 1);
    check_eq("t5b_sum", bus4.out_sum, 0);

    // 6: NUM_SAMPLES=1 goes straight to DONE
    check_eq("t6_pre_valid", bus1.out_valid, 0);
    bus1.in_valid = 1'b1;
    bus1.in_data  = 16'h1234;
    tick();
    bus1.in_valid = 1'b0;
    check_eq("t6_valid", bus1.out_valid, 1);
    check_eq("t6_sum", bus1.out_sum, 16'h1234);
    check_eq("t6_busy", bus1.busy, 1);
    check_eq("t6_ready", bus1.in_ready, 0);
    bus1.out_ready = 1'b1;
    tick();
    check_eq("t6_taken", bus1.out_valid, 0);
    check_eq("t6_taken_ready", bus1.in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
